// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO shift-chain sequencer and the chain it drives.
package siso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Bits needed to hold values up to n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/siso_frame_cnt.sv
// Loadable up-counter with terminal-count compare; latency 1 cycle (load/increment visible next cycle).
// No backpressure: load has priority over increment, tc is purely combinational on the count.
module siso_frame_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == terminal);

endmodule

// File: rtl/siso_seq_ctrl.sv
// Serialises an accepted word into a DEPTH-stage shift chain, flushes it with zeros, then idles GAP cycles.
// Latency: first bit on sr_din the cycle after accept; frame bits reach the chain output DEPTH cycles later.
// Backpressure: in_ready is low for the whole frame and gap, and for one cycle after reset or abort.
module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int GAP       = 2,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             sr_din,
    output logic             sr_en,
    output logic             sr_clr,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH + DEPTH + GAP + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_FLUSH = ST_FLUSH;
    localparam logic [1:0] S_GAP   = ST_GAP;

    localparam logic [CW-1:0] T_SHIFT = CW'(WIDTH);
    localparam logic [CW-1:0] T_FLUSH = CW'(WIDTH + DEPTH);
    localparam logic [CW-1:0] T_GAP   = CW'(GAP);
    localparam logic [CW-1:0] T_VALID = CW'(DEPTH + 1);

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] bit_mask;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_term;
    logic [CW-1:0]    bit_idx;
    logic             cnt_load, cnt_inc, cnt_tc;
    logic             accept;
    logic             abort_hit;

    assign accept    = in_valid && in_ready;
    assign abort_hit = abort && (state != S_IDLE);

    siso_frame_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .load_val (CW'(1)),
        .terminal (cnt_term),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    always_comb begin
        cnt_term = T_GAP;
        case (state)
            S_SHIFT: cnt_term = T_SHIFT;
            S_FLUSH: cnt_term = T_FLUSH;
            default: cnt_term = T_GAP;
        endcase
    end

    // One counter serves both phases: it runs 1..WIDTH+DEPTH through SHIFT/FLUSH, then reloads for the gap.
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n  = S_SHIFT;
                    cnt_load = 1'b1;
                end
            end
            S_SHIFT: begin
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    state_n = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_tc) begin
                    if (GAP == 0) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n  = S_GAP;
                        cnt_load = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                if (cnt_tc) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        endcase
        if (abort_hit) begin
            state_n  = S_IDLE;
            cnt_load = 1'b0;
            cnt_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sr_clr <= 1'b1;
            word   <= '0;
        end else begin
            state  <= state_n;
            sr_clr <= abort_hit;
            if (accept) begin
                word <= in_data;
            end
        end
    end

    // Frame cycle k+1 carries word bit k in send order.
    assign bit_idx = cnt - CW'(1);

    always_comb begin
        if (LSB_FIRST != 0) begin
            bit_mask = LSB_ONE << bit_idx;
        end else begin
            bit_mask = MSB_ONE >> bit_idx;
        end
    end

    assign in_ready  = (state == S_IDLE) && !sr_clr;
    assign busy      = (state != S_IDLE);
    assign sr_en     = (state == S_SHIFT) || (state == S_FLUSH);
    assign sr_din    = (state == S_SHIFT) && (|(word & bit_mask));
    assign bit_valid = sr_en && (cnt >= T_VALID);
    assign done      = (state == S_FLUSH) && (cnt == T_FLUSH);

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Directed bench for siso_seq_ctrl: default, LSB-first and zero-gap instances with a shift-chain model.
module tb_siso_seq_ctrl;
    import siso_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;

    logic a_rdy, a_din, a_en, a_clr, a_bv, a_busy, a_done;
    logic b_rdy, b_din, b_en, b_clr, b_bv, b_busy, b_done;
    logic c_rdy, c_din, c_en, c_clr, c_bv, c_busy, c_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    siso_seq_ctrl u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy),
        .abort(abort), .sr_din(a_din), .sr_en(a_en), .sr_clr(a_clr), .bit_valid(a_bv),
        .busy(a_busy), .done(a_done)
    );

    siso_seq_ctrl #(.LSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy),
        .abort(abort), .sr_din(b_din), .sr_en(b_en), .sr_clr(b_clr), .bit_valid(b_bv),
        .busy(b_busy), .done(b_done)
    );

    siso_seq_ctrl #(.GAP(0)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(c_rdy),
        .abort(abort), .sr_din(c_din), .sr_en(c_en), .sr_clr(c_clr), .bit_valid(c_bv),
        .busy(c_busy), .done(c_done)
    );

    // Shift chain attached to instance A.
    logic [DEF_DEPTH-1:0] chain;
    logic                 chain_out;
    always @(posedge clk) begin
        if (rst || a_clr) begin
            chain <= '0;
        end else if (a_en) begin
            chain <= {chain[DEF_DEPTH-2:0], a_din};
        end
    end
    assign chain_out = chain[DEF_DEPTH-1];

    typedef struct {
        logic din;
        logic en;
        logic bv;
        logic done;
        logic rdy;
        logic busy;
        logic chain;
    } vec_t;

    vec_t vec [1:15];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench in cycle 0 of a fresh run with in_ready expected high.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc = -1;
        check("rst_clr", a_clr, 1'b1);
        check("rst_rdy", a_rdy, 1'b0);
        check("rst_en",  a_en,  1'b0);
        check("rst_busy", a_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        cyc = 0;
        check("post_rst_clr", a_clr, 1'b0);
        check("post_rst_rdy", a_rdy, 1'b1);
    endtask

    int dcount;

    initial begin
        //                din   en    bv    done  rdy   busy  chain
        vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Basic MSB-first frame, 8'hA5, table driven.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) in_valid = 1'b0;
            check("t1_din",   a_din,     vec[c].din);
            check("t1_en",    a_en,      vec[c].en);
            check("t1_bv",    a_bv,      vec[c].bv);
            check("t1_done",  a_done,    vec[c].done);
            check("t1_rdy",   a_rdy,     vec[c].rdy);
            check("t1_busy",  a_busy,    vec[c].busy);
            check("t1_chain", chain_out, vec[c].chain);
        end

        // LSB-first, 8'h01.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) in_valid = 1'b0;
            check("t2_din", b_din, (c == 1));
            check("t2_en",  b_en,  1'b1);
        end

        // Back-to-back words with in_valid held.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hF0;
        dcount   = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1)  in_data  = 8'h0F;
            if (c == 16) in_valid = 1'b0;
            if (a_done) dcount++;
            check("t3_done", a_done, (c == 12) || (c == 27));
            if (c >= 16 && c <= 23) check("t3_din", a_din, (c >= 20));
            if (c == 14) check("t3_rdy14", a_rdy, 1'b0);
            if (c == 15) check("t3_rdy15", a_rdy, 1'b1);
            if (c == 16) check("t3_en16", a_en, 1'b1);
        end
        n_checks++;
        if (dcount != 2) begin
            n_fail++;
            $display("FAIL t3_done_count: got %0d, expected 2", dcount);
        end

        // GAP=0 instance, 8'hFF.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) in_valid = 1'b0;
            check("t4_done", c_done, (c == 12));
            check("t4_din",  c_din,  (c <= 8));
            check("t4_rdy",  c_rdy,  1'b0);
        end
        tick();
        check("t4_rdy13", c_rdy, 1'b1);
        check("t4_busy13", c_busy, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h80;
        tick();
        in_valid = 1'b0;
        check("t4_busy14", c_busy, 1'b1);
        check("t4_din14",  c_din,  1'b1);
        check("t4_rdy14",  c_rdy,  1'b0);

        // Abort in cycle 6, then abort in IDLE alongside an accept.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) in_valid = 1'b0;
        end
        check("t5_busy6", a_busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy7", a_busy, 1'b0);
        check("t5_clr7",  a_clr,  1'b1);
        check("t5_en7",   a_en,   1'b0);
        check("t5_bv7",   a_bv,   1'b0);
        check("t5_done7", a_done, 1'b0);
        check("t5_rdy7",  a_rdy,  1'b0);
        tick();
        check("t5_rdy8", a_rdy, 1'b1);
        check("t5_clr8", a_clr, 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t5_busy9", a_busy, 1'b1);
        check("t5_clr9",  a_clr,  1'b0);
        check("t5_din9",  a_din,  1'b0);
        tick();
        tick();
        check("t5_din11", a_din, 1'b1);
        check("t5_done11", a_done, 1'b0);

        // Reset in frame cycle 3, then a fresh frame.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) in_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_clr4",  a_clr,  1'b1);
        check("t6_busy4", a_busy, 1'b0);
        check("t6_en4",   a_en,   1'b0);
        check("t6_din4",  a_din,  1'b0);
        check("t6_rdy4",  a_rdy,  1'b0);
        check("t6_bv4",   a_bv,   1'b0);
        check("t6_done4", a_done, 1'b0);
        tick();
        check("t6_clr5", a_clr, 1'b0);
        check("t6_rdy5", a_rdy, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h81;
        for (int f = 1; f <= 13; f++) begin
            tick();
            if (f == 1) in_valid = 1'b0;
            check("t6_din",  a_din,  (f == 1) || (f == 8));
            check("t6_done", a_done, (f == 12));
            check("t6_bv",   a_bv,   (f >= 5) && (f <= 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
